deser_8: RTL

- Serial-in, parallel-out receiver: the far end of the team's 8-bit parallel-load / serial-shift-out register.
- Collects WIDTH serial bits, qualified by a per-bit enable strobe, into one word.
- Presents the word with a Valid/Ack handshake and flags bits that arrive while a word is still unacknowledged.
- Used as the receive side of serial links between lab datapath blocks and in testbench loopback of the shift-out register.

---
 rtl/deser_8_if.sv | 27 ++
 rtl/deser_8.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/deser_8_if.sv
// Serial-in receiver bus: strobed serial input and Ack in, word plus status out.
// The producer/consumer side takes the master modport; the receiver takes slave.
interface deser_8_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             Start;
    logic             Shift_In;
    logic             Shift_En;
    logic             Ack;
    logic [WIDTH-1:0] Data_Out;
    logic             Valid;
    logic             Busy;
    logic [CNT_W-1:0] Bit_Count;
    logic             Overrun;

    modport master (
        output Start, Shift_In, Shift_En, Ack,
        input  Data_Out, Valid, Busy, Bit_Count, Overrun
    );

    modport slave (
        input  Start, Shift_In, Shift_En, Ack,
        output Data_Out, Valid, Busy, Bit_Count, Overrun
    );
endinterface

// File: rtl/deser_8.sv
// Serial-in, parallel-out receiver. Collects WIDTH strobed bits into a word,
// holds it under a Valid/Ack handshake and flags bits dropped while waiting.
module deser_8 #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    deser_8_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] sr_r;
    logic [WIDTH-1:0] sr_nxt_s;
    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             ovr_r;
    logic             ovr_nxt_s;
    logic             valid_r;
    logic             busy_r;

    // Shift register value with the current serial bit inserted at the entry end.
    always_comb begin
        shifted_s = sr_r;
        if (LSB_FIRST != 0) begin
            shifted_s = {bus.Shift_In, sr_r[WIDTH-1:1]};
        end else begin
            shifted_s = {sr_r[WIDTH-2:0], bus.Shift_In};
        end
    end

    // Next-state and next-datapath decode; Start wins over a same-cycle strobe.
    always_comb begin
        state_nxt_s = state_r;
        sr_nxt_s    = sr_r;
        cnt_nxt_s   = cnt_r;
        data_nxt_s  = data_r;
        ovr_nxt_s   = ovr_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_nxt_s = ST_RECV;
                    sr_nxt_s    = WORD_ZERO;
                    cnt_nxt_s   = CNT_ZERO;
                    ovr_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (bus.Start) begin
                    // Restart: partial word is discarded, last word stays put.
                    sr_nxt_s  = WORD_ZERO;
                    cnt_nxt_s = CNT_ZERO;
                    ovr_nxt_s = 1'b0;
                end else if (bus.Shift_En) begin
                    sr_nxt_s = shifted_s;
                    if (cnt_r == CNT_LAST) begin
                        data_nxt_s  = shifted_s;
                        cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s = ST_DONE;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_nxt_s = ST_RECV;
                end
            end
            ST_DONE: begin
                // Any strobe here is a lost bit; an accepted Start clears the flag.
                if (bus.Shift_En) begin
                    ovr_nxt_s = 1'b1;
                end else begin
                    ovr_nxt_s = ovr_r;
                end
                if (bus.Ack) begin
                    if (bus.Start) begin
                        state_nxt_s = ST_RECV;
                        sr_nxt_s    = WORD_ZERO;
                        cnt_nxt_s   = CNT_ZERO;
                        ovr_nxt_s   = 1'b0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                sr_nxt_s    = WORD_ZERO;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and registered status outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sr_r    <= WORD_ZERO;
            data_r  <= WORD_ZERO;
            cnt_r   <= CNT_ZERO;
            ovr_r   <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            sr_r    <= sr_nxt_s;
            data_r  <= data_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ovr_r   <= ovr_nxt_s;
            valid_r <= (state_nxt_s == ST_DONE);
            busy_r  <= (state_nxt_s == ST_RECV);
        end
    end

    assign bus.Data_Out  = data_r;
    assign bus.Valid     = valid_r;
    assign bus.Busy      = busy_r;
    assign bus.Bit_Count = cnt_r;
    assign bus.Overrun   = ovr_r;
endmodule
